// File: rtl/dsram_bank.sv
// rtl/dsram_bank.sv - byte-masked single-bank SRAM with zero-fill init and pipelined reads
module dsram_bank #(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 256,
    parameter int RD_LAT        = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     a,
    input  logic                      read,
    input  logic [ADDR_WIDTH-1:0]     aq,
    input  logic                      write,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [DATA_WIDTH-1:0]     wd,
    output logic [DATA_WIDTH-1:0]     rd,
    output logic                      rd_valid,
    output logic                      ready
);

    localparam int ENTRIES  = 2**ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH/8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ENTRIES-1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_mem [ENTRIES];
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic                    r_s1_valid;

    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic                    w_init_wr;
    logic [DATA_WIDTH-1:0]   w_wr_old;
    logic [DATA_WIDTH-1:0]   w_wr_merged;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Requests only count once the bank is running; the init walk owns the array before that.
    assign w_wr_acc  = write & r_ready;
    assign w_rd_acc  = read  & r_ready;
    assign w_init_wr = (r_state == ST_INIT) && (INIT_ON_RESET != 0) && rst_n;

    // Init/run FSM: walk every row once after reset, then open the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if ((INIT_ON_RESET == 0) || (r_init_cnt == LAST_ROW)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Byte merge of the addressed write row; also the write-first bypass for same-row reads.
    always_comb begin
        w_wr_old    = r_mem[aq];
        w_wr_merged = w_wr_old;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                w_wr_merged[8*i +: 8] = wd[8*i +: 8];
            end
        end
    end

    // Read source: forward the merged row when the same row is written on this edge.
    always_comb begin
        w_rd_data = r_mem[a];
        if (w_wr_acc && (aq == a)) begin
            w_rd_data = w_wr_merged;
        end
    end

    // Array storage has no reset; only the init walk clears it.
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_mem[aq] <= w_wr_merged;
        end
    end

    // First read stage: data is captured here, so later writes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            r_s1_data  <= w_rd_acc ? w_rd_data : '0;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            // Second read stage: pure delay of the captured row, zero when idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_data  <= r_s1_data;
                end
            end

            assign rd       = r_s2_data;
            assign rd_valid = r_s2_valid;
        end else begin : g_lat1
            assign rd       = r_s1_data;
            assign rd_valid = r_s1_valid;
        end
    endgenerate

    assign ready = r_ready;

endmodule
